// File: rtl/hamming_enc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hamming_enc_sched_pkg
// Brief    : Shared constants, FSM state type and helpers for the SECDED
//            (72,64) encoder scheduler.
// Revision : 1.0
// ============================================================================
package hamming_enc_sched_pkg;

    localparam int DATA_W = 64;
    localparam int CODE_W = 72;
    localparam int c_PAR_N = 7;

    localparam logic [6:0] c_PAR_POS [c_PAR_N] = '{
        7'd1, 7'd2, 7'd4, 7'd8, 7'd16, 7'd32, 7'd64
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Hamming positions that are powers of two carry parity, not data.
    function automatic logic isPow2(input logic [6:0] pos);
        return (pos & (pos - 7'd1)) == 7'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_enc_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : hamming_enc_sched_if
// Brief    : Requester, consumer and counter signals of the encoder scheduler.
// Revision : 1.0
// ============================================================================
interface hamming_enc_sched_if
    import hamming_enc_sched_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              out_valid;
    logic [CODE_W-1:0] out_code;
    logic              out_src;
    logic              out_ready;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_code, out_src, cnt0, cnt1
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_code, out_src, cnt0, cnt1
    );

endinterface
`default_nettype wire

// File: rtl/hamming_enc72_core.sv
`default_nettype none
// ============================================================================
// Module   : hamming_enc72_core
// Brief    : Combinational SECDED (72,64) encoder, Hamming positions 1..71
//            plus overall even parity in bit 0.
// Revision : 1.0
// ============================================================================
module hamming_enc72_core
    import hamming_enc_sched_pkg::*;
(
    input  wire logic [DATA_W-1:0] i_data,
    output logic      [CODE_W-1:0] o_code
);

    always_comb begin
        logic [6:0] w_idx;
        logic [6:0] w_syn;
        o_code = '0;
        w_idx  = '0;
        w_syn  = '0;
        // Data bits go to non-power-of-two positions in ascending order; the
        // XOR of the positions holding a 1 is exactly the parity word.
        for (int p = 1; p < CODE_W; p++) begin
            if (!isPow2(7'(p))) begin
                o_code[7'(p)] = i_data[w_idx[5:0]];
                if (i_data[w_idx[5:0]]) begin
                    w_syn = w_syn ^ 7'(p);
                end
                w_idx = w_idx + 7'd1;
            end
        end
        for (int k = 0; k < c_PAR_N; k++) begin
            o_code[c_PAR_POS[k]] = w_syn[3'(k)];
        end
        o_code[0] = ^o_code[CODE_W-1:1];
    end

endmodule
`default_nettype wire

// File: rtl/hamming_enc_sched.sv
`default_nettype none
// ============================================================================
// Module   : hamming_enc_sched
// Brief    : Two-requester arbiter feeding a registered SECDED (72,64) encoder.
// Revision : 1.0
// ============================================================================
module hamming_enc_sched
    import hamming_enc_sched_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter bit RR_EN = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    hamming_enc_sched_if.slave bus
);

    state_t            r_state;
    logic [DATA_W-1:0] r_din;
    logic              r_src;
    logic              r_lastSrc;
    logic              r_outValid;
    logic              r_outSrc;
    logic [CODE_W-1:0] r_outCode;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic              w_pick1;
    logic              w_grant0;
    logic              w_idle;
    logic              w_accept;
    logic [CODE_W-1:0] w_code;

    // On a tie, round-robin serves whoever was not served last.
    assign w_pick1  = bus.req1_valid && (!bus.req0_valid || (RR_EN && !r_lastSrc));
    assign w_grant0 = bus.req0_valid && !w_pick1;
    assign w_idle   = (r_state == S_IDLE) && !rst;
    assign w_accept = w_idle && (w_grant0 || w_pick1);

    assign bus.req0_ready = w_idle && w_grant0;
    assign bus.req1_ready = w_idle && w_pick1;
    assign bus.out_valid  = r_outValid;
    assign bus.out_code   = r_outCode;
    assign bus.out_src    = r_outSrc;
    assign bus.cnt0       = r_cnt0;
    assign bus.cnt1       = r_cnt1;

    hamming_enc72_core u_core (
        .i_data (r_din),
        .o_code (w_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_din      <= '0;
            r_src      <= 1'b0;
            r_lastSrc  <= 1'b1;
            r_outValid <= 1'b0;
            r_outSrc   <= 1'b0;
            r_outCode  <= '0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_din     <= w_pick1 ? bus.req1_data : bus.req0_data;
                        r_src     <= w_pick1;
                        r_lastSrc <= w_pick1;
                        if (w_pick1) begin
                            if (r_cnt1 != '1) r_cnt1 <= r_cnt1 + 1'b1;
                        end else begin
                            if (r_cnt0 != '1) r_cnt0 <= r_cnt0 + 1'b1;
                        end
                        r_state <= S_ENC;
                    end
                end
                S_ENC: begin
                    r_outCode  <= w_code;
                    r_outSrc   <= r_src;
                    r_outValid <= 1'b1;
                    r_state    <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/hamming_enc_sched.md
HAMMING_ENC_SCHED -- requirements
Module: hamming_enc_sched

Interface
REQ-001 Parameter: CNT_W, default 16, width of each per-requester accepted-word counter.
REQ-002 Parameter: RR_EN, default 1; 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req0_valid  input  1  requester 0 has a 64-bit data word to encode.
REQ-006 Port: req0_data  input  64  requester 0 data word.
REQ-007 Port: req0_ready  output  1  requester 0 word accepted this cycle when high with req0_valid.
REQ-008 Ports: req1_valid / req1_data / req1_ready  input / input / output  1 / 64 / 1  requester 1, same meaning.
REQ-009 Port: out_valid  output  1  out_code holds a valid codeword.
REQ-010 Port: out_code  output  72  SECDED (72,64) codeword.
REQ-011 Port: out_src  output  1  index of the requester that supplied out_code.
REQ-012 Port: out_ready  input  1  consumer accepts out_code this cycle when high with out_valid.
REQ-013 Ports: cnt0 / cnt1  output  CNT_W  words accepted from requester 0 / 1.

Function
REQ-014 FSM states IDLE, ENC, OUT; one word in flight at a time.
REQ-015 IDLE: readyN = 1 only for granted requester N; both ready low if no valid request; ready is combinational from state, valids, and pointer.
REQ-016 Arbitration, RR_EN=1: single valid requester wins; both valid -> grant goes to the requester not served last (pointer last_src).
REQ-017 Arbitration, RR_EN=0: req0 wins whenever req0_valid=1.
REQ-018 On accept (valid & ready in IDLE): latch data to din_q and index to src_q, update last_src, increment that requester's counter, go to ENC.
REQ-019 ENC: register out_code = encode(din_q), out_src = src_q, out_valid <= 1; go to OUT; both ready low.
REQ-020 OUT: out_code, out_src, and out_valid held stable; both ready low; on out_ready=1 clear out_valid and go to IDLE.
REQ-021 Latency: codeword appears with out_valid high 2 cycles after the accept edge; minimum 3 cycles per word.
REQ-022 Encode, codeword bit p = Hamming position p (p = 1..71): parity bits at p = 1, 2, 4, 8, 16, 32, 64.
REQ-023 Encode, data placement: data bits 0..63 fill the non-power-of-two positions 3..71 in ascending order.
REQ-024 Encode, parity values: parity bit 2^k = XOR of bit k over the positions of all data bits equal to 1.
REQ-025 Encode, overall parity: bit 0 = XOR of codeword bits 1..71 (even overall parity).
REQ-026 Counters saturate at all-ones; they never wrap.
REQ-027 Requester valid deasserting in IDLE without accept has no effect; data is not sampled.
REQ-028 out_ready held high while not in OUT is ignored.

Reset
REQ-029 On rst=1: state to IDLE; out_valid=0, out_code=0, out_src=0; cnt0=cnt1=0; din_q=0; last_src=1 (req0 first on tie); both ready low during the reset cycle.
REQ-030 rst asserted in ENC or OUT discards the in-flight word; no codeword is presented for it.

Structure
REQ-031 Shared package holds state enum, parity-position constants (1, 2, 4, 8, 16, 32, 64), and the DATA_W=64 and CODE_W=72 constants.
REQ-032 Encoder is a combinational sub-module hamming_enc72_core (64-bit in, 72-bit out) instantiated once and fed from din_q.

Verification
REQ-033 Single word: req0 sends 64'h0 with out_ready=1 -> out_code=72'h0, out_src=0, valid 2 cycles after accept, cnt0=1.
REQ-034 Single word: req1 sends 64'h1 -> out_code=72'h00_0000_0000_0000_000F, out_src=1.
REQ-035 Single word: req0 sends 64'h8000_0000_0000_0000 -> out_code=72'h81_0000_0000_0000_0017.
REQ-036 Contention: both valid continuously for 4 words, RR_EN=1 -> out_src sequence 0,1,0,1; with RR_EN=0 -> 0,0,0,0.
REQ-037 Backpressure and reset: out_ready low for 5 cycles in OUT -> out_code stable and both ready low throughout; rst pulsed in ENC -> out_valid stays 0, state IDLE next cycle.
REQ-038 Saturation: CNT_W=2 with 5 req0 accepts -> cnt0 stops at 3.
